// File: rtl/fifo_burst_reader_if.sv
// Bundles the command, FIFO read-side and output-stream signals of fifo_burst_reader.
// slave is the reader's view; master is the view of whatever drives and observes it.
interface fifo_burst_reader_if #(
    parameter int unsigned DataWidth = 16,
    parameter int unsigned MaxBurst  = 8
);
    localparam int unsigned LenWidth = $clog2(MaxBurst + 1);

    logic                 i_start;
    logic [LenWidth-1:0]  i_len;
    logic                 i_abort;
    logic                 o_busy;
    logic                 o_done;
    logic                 o_fifo_rd_en;
    logic [DataWidth-1:0] i_fifo_rd_data;
    logic                 i_fifo_empty;
    logic [DataWidth-1:0] o_data;
    logic                 o_valid;
    logic                 o_last;
    logic                 i_ready;

    modport slave (
        input  i_start, i_len, i_abort, i_fifo_rd_data, i_fifo_empty, i_ready,
        output o_busy, o_done, o_fifo_rd_en, o_data, o_valid, o_last
    );

    modport master (
        output i_start, i_len, i_abort, i_fifo_rd_data, i_fifo_empty, i_ready,
        input  o_busy, o_done, o_fifo_rd_en, o_data, o_valid, o_last
    );
endinterface

// File: rtl/fifo_burst_reader.sv
// Pops one commanded burst from an FWFT FIFO and presents it as a registered
// valid/ready stream with a last flag; supports sink stalls, FIFO underrun stalls and abort.
module fifo_burst_reader #(
    parameter int unsigned DataWidth = 16,
    parameter int unsigned MaxBurst  = 8
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    fifo_burst_reader_if.slave bus_if
);
    localparam int unsigned         LenWidth = $clog2(MaxBurst + 1);
    localparam logic [LenWidth-1:0] MaxLen   = LenWidth'(MaxBurst);
    localparam logic [LenWidth-1:0] LenOne   = LenWidth'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [LenWidth-1:0]  remaining_q, remaining_d;
    logic [DataWidth-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 last_q, last_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic [LenWidth-1:0]  len_c;
    logic                 pop_c;
    logic                 accept_c;

    // Oversized requests are clamped rather than rejected.
    assign len_c    = (bus_if.i_len > MaxLen) ? MaxLen : bus_if.i_len;
    assign accept_c = valid_q && bus_if.i_ready;
    assign pop_c    = (state_q == BURST) && !bus_if.i_abort && !bus_if.i_fifo_empty &&
                      (remaining_q != '0) && (!valid_q || bus_if.i_ready);

    assign bus_if.o_fifo_rd_en = pop_c;
    assign bus_if.o_data       = data_q;
    assign bus_if.o_valid      = valid_q;
    assign bus_if.o_last       = last_q;
    assign bus_if.o_busy       = busy_q;
    assign bus_if.o_done       = done_q;

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        data_d      = data_q;
        valid_d     = valid_q;
        last_d      = last_q;

        case (state_q)
            IDLE: begin
                if (bus_if.i_start) begin
                    if (len_c == '0) begin
                        state_d = DONE;
                    end else begin
                        remaining_d = len_c;
                        state_d     = BURST;
                    end
                end
            end
            BURST: begin
                if (bus_if.i_abort) begin
                    valid_d     = 1'b0;
                    last_d      = 1'b0;
                    remaining_d = '0;
                    state_d     = DONE;
                end else if (pop_c) begin
                    data_d      = bus_if.i_fifo_rd_data;
                    valid_d     = 1'b1;
                    last_d      = (remaining_q == LenOne);
                    remaining_d = remaining_q - LenOne;
                    if (remaining_q == LenOne) begin
                        state_d = DRAIN;
                    end
                end else if (accept_c) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                end
            end
            DRAIN: begin
                if (bus_if.i_abort) begin
                    valid_d     = 1'b0;
                    last_d      = 1'b0;
                    remaining_d = '0;
                    state_d     = DONE;
                end else if (accept_c || !valid_q) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The done pulse trails the DONE state by one cycle so it lands in the following IDLE cycle.
    assign busy_d = (state_d != IDLE);
    assign done_d = (state_q == DONE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            last_q      <= last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end
endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader: an FWFT FIFO model feeds the reader and a
// scoreboard of expected stream words is filled when each burst is commanded.
module tb_fifo_burst_reader;
    localparam int unsigned DW = 16;
    localparam int unsigned MB = 8;
    localparam int unsigned LW = $clog2(MB + 1);

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    logic clk;
    logic rst_n;

    fifo_burst_reader_if #(.DataWidth(DW), .MaxBurst(MB)) bus_if ();

    fifo_burst_reader #(.DataWidth(DW), .MaxBurst(MB)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus_if  (bus_if.slave)
    );

    // FWFT FIFO model: writes come from the stimulus, pops from the DUT.
    logic [DW-1:0] mem [0:255];
    int            wr_ptr = 0;
    int            rd_ptr = 0;

    assign bus_if.i_fifo_rd_data = mem[rd_ptr];
    assign bus_if.i_fifo_empty   = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (bus_if.o_fifo_rd_en) rd_ptr <= rd_ptr + 1;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            n_cmp = 0;
    int            n_err = 0;
    exp_t          exp_q[$];
    logic [DW-1:0] model_q[$];

    int            cyc = 0;
    int            n_pops = 0;
    int            pops0;
    int            start_cyc;
    int            first_valid_cyc;
    int            prev_valid_cyc;
    int            last_accept_cyc;
    int            max_gap;
    logic          valid_seen;
    logic          stall_prev = 1'b0;
    logic [DW-1:0] held_data;
    logic          held_last;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fifo_write(input logic [DW-1:0] d);
        mem[wr_ptr] = d;
        wr_ptr++;
    endtask

    task automatic push_word(input logic [DW-1:0] d);
        fifo_write(d);
        model_q.push_back(d);
    endtask

    // Observe one cycle mid-period, then advance to the next falling edge.
    task automatic tick();
        exp_t e;
        #1;
        if (bus_if.o_valid && bus_if.i_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb_underrun", 32'(exp_q.size()), 32'(1));
            end else begin
                e = exp_q.pop_front();
                chk("data", 32'(bus_if.o_data), 32'(e.data));
                chk("last", 32'(bus_if.o_last), 32'(e.last));
            end
            if (bus_if.o_last) last_accept_cyc = cyc;
        end
        if (bus_if.o_fifo_rd_en) begin
            n_pops++;
            chk("pop_nonempty", 32'(bus_if.i_fifo_empty), 32'(0));
            chk("pop_gate", 32'(!bus_if.o_valid || bus_if.i_ready), 32'(1));
        end
        if (stall_prev) begin
            chk("hold_valid", 32'(bus_if.o_valid), 32'(1));
            chk("hold_data", 32'(bus_if.o_data), 32'(held_data));
            chk("hold_last", 32'(bus_if.o_last), 32'(held_last));
        end
        if (bus_if.o_valid) begin
            valid_seen = 1'b1;
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
            if (prev_valid_cyc >= 0 && (cyc - prev_valid_cyc - 1) > max_gap)
                max_gap = cyc - prev_valid_cyc - 1;
            prev_valid_cyc = cyc;
        end
        stall_prev = bus_if.o_valid && !bus_if.i_ready && !bus_if.i_abort;
        held_data  = bus_if.o_data;
        held_last  = bus_if.o_last;
        cyc++;
        @(negedge clk);
    endtask

    // Command a burst; the first n_exp words it should deliver go to the scoreboard.
    task automatic launch(input int len, input int n_exp);
        int   n;
        exp_t e;
        n = (len > int'(MB)) ? int'(MB) : len;
        for (int i = 0; i < n_exp; i++) begin
            e.data = model_q.pop_front();
            e.last = (i == n - 1);
            exp_q.push_back(e);
        end
        first_valid_cyc = -1;
        prev_valid_cyc  = -1;
        last_accept_cyc = -1;
        max_gap         = 0;
        valid_seen      = 1'b0;
        pops0           = n_pops;
        start_cyc       = cyc;
        bus_if.i_start  = 1'b1;
        bus_if.i_len    = LW'(len);
        tick();
        bus_if.i_start  = 1'b0;
        #1;
        chk("busy_after_start", 32'(bus_if.o_busy), 32'(1));
    endtask

    // Advance until o_done is seen in the current cycle; leaves the bench in that cycle.
    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (k < budget) begin
            #1;
            if (bus_if.o_done === 1'b1) break;
            tick();
            k++;
        end
        chk("done_seen", 32'(bus_if.o_done), 32'(1));
        chk("done_not_busy", 32'(bus_if.o_busy), 32'(0));
        chk("sb_drained", 32'(exp_q.size()), 32'(0));
    endtask

    initial begin
        rst_n          = 1'b0;
        bus_if.i_start = 1'b0;
        bus_if.i_len   = '0;
        bus_if.i_abort = 1'b0;
        bus_if.i_ready = 1'b1;

        // Reset state
        #6;
        chk("rst_busy", 32'(bus_if.o_busy), 32'(0));
        chk("rst_done", 32'(bus_if.o_done), 32'(0));
        chk("rst_valid", 32'(bus_if.o_valid), 32'(0));
        chk("rst_last", 32'(bus_if.o_last), 32'(0));
        chk("rst_rden", 32'(bus_if.o_fifo_rd_en), 32'(0));
        chk("rst_data", 32'(bus_if.o_data), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();

        // Four of eight words, full-rate sink
        for (int i = 0; i < 8; i++) push_word(DW'(16'hA000 + i));
        launch(4, 4);
        wait_done(40);
        chk("t2_first_valid_lat", 32'(first_valid_cyc - start_cyc), 32'(2));
        chk("t2_done_after_last", 32'(cyc - last_accept_cyc), 32'(2));
        chk("t2_pops", 32'(n_pops - pops0), 32'(4));
        chk("t2_fifo_left", 32'(wr_ptr - rd_ptr), 32'(4));

        // Zero length, started back-to-back in the done cycle
        launch(0, 0);
        wait_done(20);
        chk("t3_len0_done_lat", 32'(cyc - start_cyc), 32'(2));
        chk("t3_len0_pops", 32'(n_pops - pops0), 32'(0));
        chk("t3_len0_valid", 32'(valid_seen), 32'(0));

        // Oversized request is clamped to MaxBurst
        for (int i = 0; i < 8; i++) push_word(DW'(16'hB000 + i));
        launch(15, 8);
        wait_done(60);
        chk("t3_len15_pops", 32'(n_pops - pops0), 32'(8));
        chk("t3_len15_fifo_left", 32'(wr_ptr - rd_ptr), 32'(4));

        // Sink toggling 1,0,0,1 over a six-word burst
        push_word(16'hD000);
        push_word(16'hD001);
        launch(6, 6);
        for (int k = 0; k < 80; k++) begin
            #1;
            if (bus_if.o_done === 1'b1) break;
            bus_if.i_ready = (k % 4 == 0) || (k % 4 == 3);
            tick();
        end
        bus_if.i_ready = 1'b1;
        chk("t5_done_seen", 32'(bus_if.o_done), 32'(1));
        chk("t5_sb_drained", 32'(exp_q.size()), 32'(0));
        chk("t5_pops", 32'(n_pops - pops0), 32'(6));
        chk("t5_fifo_empty", 32'(wr_ptr - rd_ptr), 32'(0));

        // FIFO runs dry after two words and is refilled later
        push_word(16'hC000);
        push_word(16'hC001);
        model_q.push_back(16'hC002);
        model_q.push_back(16'hC003);
        launch(4, 4);
        for (int i = 0; i < 7; i++) tick();
        chk("t4_stalled_busy", 32'(bus_if.o_busy), 32'(1));
        fifo_write(16'hC002);
        fifo_write(16'hC003);
        wait_done(40);
        chk("t4_gap_ge4", 32'(max_gap >= 4), 32'(1));
        chk("t4_pops", 32'(n_pops - pops0), 32'(4));

        // Abort after two accepted words, with the third held and not accepted
        for (int i = 0; i < 8; i++) push_word(DW'(16'hE000 + i));
        launch(6, 2);
        tick();
        tick();
        tick();
        bus_if.i_abort = 1'b1;
        bus_if.i_ready = 1'b0;
        #1;
        chk("t6_abort_rden", 32'(bus_if.o_fifo_rd_en), 32'(0));
        tick();
        bus_if.i_abort = 1'b0;
        bus_if.i_ready = 1'b1;
        #1;
        chk("t6_valid_after_abort", 32'(bus_if.o_valid), 32'(0));
        chk("t6_last_after_abort", 32'(bus_if.o_last), 32'(0));
        wait_done(10);
        chk("t6_pops", 32'(n_pops - pops0), 32'(3));
        chk("t6_fifo_left", 32'(wr_ptr - rd_ptr), 32'(5));
        for (int i = 0; i < (n_pops - pops0 - 2); i++) void'(model_q.pop_front());

        // Asynchronous reset in the middle of a burst
        launch(4, 4);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("t1_rst_valid", 32'(bus_if.o_valid), 32'(0));
        chk("t1_rst_busy", 32'(bus_if.o_busy), 32'(0));
        chk("t1_rst_last", 32'(bus_if.o_last), 32'(0));
        chk("t1_rst_rden", 32'(bus_if.o_fifo_rd_en), 32'(0));
        chk("t1_rst_data", 32'(bus_if.o_data), 32'(0));
        chk("t1_rst_done", 32'(bus_if.o_done), 32'(0));
        exp_q.delete();
        stall_prev = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        #1;
        chk("t1_idle_busy", 32'(bus_if.o_busy), 32'(0));
        chk("t1_idle_valid", 32'(bus_if.o_valid), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
